// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module     : cdb_arbiter_if
// Description: Functional-unit request bus and registered CDB broadcast bus
//              shared between the units and cdb_arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int SRC_WIDTH = $clog2(NUM_REQ);

    logic                            flush;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_data;
    logic                            cdb_valid;
    logic [TAG_WIDTH-1:0]            cdb_tag;
    logic [DATA_WIDTH-1:0]           cdb_data;
    logic [SRC_WIDTH-1:0]            cdb_src;

    modport master (
        output flush, req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  flush, req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : cdb_arbiter
// Description: Round-robin arbiter sharing one registered common data bus
//              among NUM_REQ single-slot functional-unit result buffers.
//              Optional macro CDB_ARB_STATS_EN adds grant/stall counters.
// Revision   : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cdb_arbiter_if.slave          bus
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] stat_grants,
    output logic [15:0]           stat_stall
`endif
);
    localparam int                 SRC_W     = $clog2(NUM_REQ);
    localparam int                 c_IDX_W   = SRC_W + 1;
    localparam logic [c_IDX_W-1:0] c_NUM_REQ = c_IDX_W'(NUM_REQ);
    localparam logic [SRC_W-1:0]   c_LAST    = SRC_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]     r_slot_v;
    logic [TAG_WIDTH-1:0]   r_slot_tag  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  r_slot_data [NUM_REQ];
    logic [SRC_W-1:0]       r_rr_ptr;

    logic                   r_cdb_valid;
    logic [TAG_WIDTH-1:0]   r_cdb_tag;
    logic [DATA_WIDTH-1:0]  r_cdb_data;
    logic [SRC_W-1:0]       r_cdb_src;

    logic [NUM_REQ-1:0]     w_grant;
    logic [NUM_REQ-1:0]     w_ready;
    logic [NUM_REQ-1:0]     w_accept;
    logic                   w_found;
    logic [SRC_W-1:0]       w_win;
    logic [c_IDX_W-1:0]     w_idx;

    // Rotating priority search beginning at r_rr_ptr; first valid slot wins.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + c_IDX_W'(k);
            if (w_idx >= c_NUM_REQ) begin
                w_idx = w_idx - c_NUM_REQ;
            end
            if (!w_found && r_slot_v[w_idx[SRC_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[SRC_W-1:0];
            end
        end
        if (w_found) begin
            w_grant[w_win] = 1'b1;
        end
    end

    // A slot being drained this cycle can take a new result at the same edge.
    assign w_ready       = {NUM_REQ{~bus.flush}} & (~r_slot_v | w_grant);
    assign w_accept      = bus.req_valid & w_ready;
    assign bus.req_ready = w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_v    <= '0;
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else if (bus.flush) begin
            r_slot_v    <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_slot_v[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_slot_v[i] <= 1'b0;
                end
            end
            if (w_found) begin
                r_cdb_valid <= 1'b1;
                r_cdb_tag   <= r_slot_tag[w_win];
                r_cdb_data  <= r_slot_data[w_win];
                r_cdb_src   <= w_win;
                r_rr_ptr    <= (w_win == c_LAST) ? '0 : w_win + SRC_W'(1);
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    // Payload is only meaningful while its valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                r_slot_tag[i]  <= bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                r_slot_data[i] <= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_data  = r_cdb_data;
    assign bus.cdb_src   = r_cdb_src;

`ifdef CDB_ARB_STATS_EN
    logic [15:0]        r_stat_grants [NUM_REQ];
    logic [15:0]        r_stat_stall;
    logic [NUM_REQ-1:0] w_bcast;

    // A grant in a flush cycle never reaches the bus, so it is not counted.
    assign w_bcast = bus.flush ? '0 : w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_grants[i] <= '0;
            end
            r_stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_bcast[i] && (r_stat_grants[i] != 16'hFFFF)) begin
                    r_stat_grants[i] <= r_stat_grants[i] + 16'd1;
                end
            end
            if (((r_slot_v & ~w_bcast) != '0) && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_out
            assign stat_grants[g*16 +: 16] = r_stat_grants[g];
        end
    endgenerate

    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire
